// File: rtl/drac_pkg.sv
// Shared fetch/decode types for the front end: the queue entry layout and default depth.
package drac_pkg;

    typedef logic [31:0] instruction_t;
    typedef logic [63:0] bus64_t;

    typedef struct packed {
        instruction_t instr;
        bus64_t       pc;
        logic         ex_valid;
    } fetch_entry_t;

    localparam int           INSTR_QUEUE_DEPTH = 4;
    localparam instruction_t INSTR_NOP         = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/id_instr_queue.sv
// Fetch-to-decode instruction queue: circular buffer with separate occupancy count,
// synchronous flush, and NOP/zero outputs whenever the queue is empty.
module id_instr_queue
    import drac_pkg::*;
#(
    parameter int DEPTH = INSTR_QUEUE_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  logic [31:0]              instr_i,
    input  logic [63:0]              pc_i,
    input  logic                     ex_valid_i,
    output logic                     ready_o,
    output logic                     valid_o,
    output logic [31:0]              instr_o,
    output logic [63:0]              pc_o,
    output logic                     ex_valid_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]         r_head;
    logic [PTR_W-1:0]         r_tail;
    logic [CNT_W-1:0]         r_count;

    logic                     w_push;
    logic                     w_pop;
    fetch_entry_t             w_in_entry;
    fetch_entry_t             w_head_entry;

    // Handshakes depend only on registered occupancy, so no input-to-ready path exists.
    assign ready_o = (r_count < CNT_W'(DEPTH));
    assign valid_o = (r_count != '0);

    assign w_push = valid_i & ready_o & ~flush_i;
    assign w_pop  = valid_o & ready_i & ~flush_i;

    assign w_in_entry   = '{instr: instr_i, pc: pc_i, ex_valid: ex_valid_i};
    assign w_head_entry = r_mem[r_head];

    assign instr_o    = valid_o ? w_head_entry.instr    : INSTR_NOP;
    assign pc_o       = valid_o ? w_head_entry.pc       : '0;
    assign ex_valid_o = valid_o ? w_head_entry.ex_valid : 1'b0;
    assign count_o    = r_count;

    // Storage is deliberately not reset; stale data is masked by count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_tail] <= w_in_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_id_instr_queue.sv
// Directed bench for id_instr_queue: reset, latency, full/back-pressure, streaming wrap,
// flush, exception tagging and asynchronous reset.
module tb_id_instr_queue;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        flush_i;
    logic        valid_i;
    logic [31:0] instr_i;
    logic [63:0] pc_i;
    logic        ex_valid_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [63:0] pc_o;
    logic        ex_valid_o;
    logic        ready_i;
    logic [2:0]  count_o;

    int errors = 0;
    int checks = 0;

    id_instr_queue #(.DEPTH(4)) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .instr_i    (instr_i),
        .pc_i       (pc_i),
        .ex_valid_i (ex_valid_i),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .instr_o    (instr_o),
        .pc_o       (pc_o),
        .ex_valid_o (ex_valid_o),
        .ready_i    (ready_i),
        .count_o    (count_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one edge; outputs are observed and inputs changed 1 time unit later.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rstn_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        instr_i = '0; pc_i = '0; ex_valid_i = 1'b0;
        step();
        step();
        rstn_i = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", valid_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", ready_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (instr_o !== 32'h13) begin errors++; $display("FAIL reset_instr got=%h exp=00000013", instr_o); end
        checks++; if (pc_o !== 64'h0 || ex_valid_o !== 1'b0) begin errors++; $display("FAIL reset_pc_ex got=%h/%0b exp=0/0", pc_o, ex_valid_o); end
    endtask

    task automatic test_single();
        ready_i = 1'b1; valid_i = 1'b1; instr_i = 32'h0050_0093; pc_i = 64'h8000_0000;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL single_nobypass got=%0b exp=0", valid_o); end
        step();
        valid_i = 1'b0;
        checks++; if (valid_o !== 1'b1 || instr_o !== 32'h0050_0093 || pc_o !== 64'h8000_0000)
            begin errors++; $display("FAIL single_out got=%0b/%h/%h exp=1/00500093/80000000", valid_o, instr_o, pc_o); end
        step();
        checks++; if (valid_o !== 1'b0 || instr_o !== 32'h13)
            begin errors++; $display("FAIL single_drain got=%0b/%h exp=0/00000013", valid_o, instr_o); end
    endtask

    task automatic test_fill();
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1; pc_i = 64'(i * 4); instr_i = 32'h1000 + 32'(i);
            step();
            if (i == 3) begin
                checks++; if (ready_o !== 1'b0 || count_o !== 3'd4)
                    begin errors++; $display("FAIL fill_full got=%0b/%0d exp=0/4", ready_o, count_o); end
            end
        end
        valid_i = 1'b0;
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL fill_fifth_blocked got=%0d exp=4", count_o); end
        ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (valid_o !== 1'b1 || pc_o !== 64'(k * 4) || instr_o !== 32'h1000 + 32'(k))
                begin errors++; $display("FAIL fill_order[%0d] got=%0b/%h/%h exp=1/%h/%h", k, valid_o, pc_o, instr_o, k * 4, 32'h1000 + k); end
            step();
        end
        checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1)
            begin errors++; $display("FAIL fill_empty got=%0b/%0b exp=0/1", valid_o, ready_o); end
    endtask

    task automatic test_full_pop();
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; pc_i = 64'h200 + 64'(i * 4); instr_i = 32'(i);
            step();
        end
        // Full: push offered alongside a pop must be refused.
        valid_i = 1'b1; pc_i = 64'hDEAD; ready_i = 1'b1;
        step();
        valid_i = 1'b0; ready_i = 1'b0;
        checks++; if (count_o !== 3'd3 || pc_o !== 64'h204)
            begin errors++; $display("FAIL full_pop got=%0d/%h exp=3/204", count_o, pc_o); end
        ready_i = 1'b1;
        for (int k = 1; k < 4; k++) begin
            checks++; if (pc_o !== 64'h200 + 64'(k * 4))
                begin errors++; $display("FAIL full_pop_order[%0d] got=%h exp=%h", k, pc_o, 64'h200 + k * 4); end
            step();
        end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL full_pop_nodeadbeef got=%0b exp=0", valid_o); end
    endtask

    task automatic test_stream();
        ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            valid_i = 1'b1; pc_i = 64'h1000 + 64'(i * 4); instr_i = 32'h2000 + 32'(i);
            step();
            checks++; if (count_o !== 3'd1 || pc_o !== 64'h1000 + 64'(i * 4) || instr_o !== 32'h2000 + 32'(i))
                begin errors++; $display("FAIL stream[%0d] got=%0d/%h/%h exp=1/%h/%h", i, count_o, pc_o, instr_o, 64'h1000 + i * 4, 32'h2000 + i); end
        end
        valid_i = 1'b0;
        step();
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL stream_drain got=%0d exp=0", count_o); end
    endtask

    task automatic test_flush();
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1; pc_i = 64'h300 + 64'(i * 4); instr_i = 32'h3;
            step();
        end
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL flush_pre got=%0d exp=3", count_o); end
        flush_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1; pc_i = 64'h3FC;
        step();
        flush_i = 1'b0; valid_i = 1'b0;
        checks++; if (count_o !== 3'd0 || valid_o !== 1'b0 || ready_o !== 1'b1)
            begin errors++; $display("FAIL flush_clear got=%0d/%0b/%0b exp=0/0/1", count_o, valid_o, ready_o); end
        valid_i = 1'b1; pc_i = 64'h500; instr_i = 32'h5;
        step();
        valid_i = 1'b0;
        checks++; if (count_o !== 3'd1 || pc_o !== 64'h500)
            begin errors++; $display("FAIL flush_after got=%0d/%h exp=1/500", count_o, pc_o); end
        step();
    endtask

    task automatic test_ex();
        logic [2:0] exp_ex;
        exp_ex = 3'b010;
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1; pc_i = 64'h400 + 64'(i * 4); instr_i = 32'h4; ex_valid_i = exp_ex[i];
            step();
        end
        valid_i = 1'b0; ex_valid_i = 1'b0; ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (ex_valid_o !== exp_ex[k] || pc_o !== 64'h400 + 64'(k * 4))
                begin errors++; $display("FAIL ex_tag[%0d] got=%0b/%h exp=%0b/%h", k, ex_valid_o, pc_o, exp_ex[k], 64'h400 + k * 4); end
            step();
        end
        checks++; if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL ex_empty got=%0b exp=0", ex_valid_o); end
    endtask

    task automatic test_async_reset();
        ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            valid_i = 1'b1; pc_i = 64'h600 + 64'(i * 4); instr_i = 32'h6;
            step();
        end
        valid_i = 1'b0;
        checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL areset_pre got=%0d exp=2", count_o); end
        #1 rstn_i = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0 || count_o !== 3'd0 || instr_o !== 32'h13)
            begin errors++; $display("FAIL areset_now got=%0b/%0d/%h exp=0/0/00000013", valid_o, count_o, instr_o); end
        #1 rstn_i = 1'b1;
        step();
        valid_i = 1'b1; pc_i = 64'h700; instr_i = 32'h7;
        step();
        valid_i = 1'b0;
        checks++; if (count_o !== 3'd1 || pc_o !== 64'h700)
            begin errors++; $display("FAIL areset_after got=%0d/%h exp=1/700", count_o, pc_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_pop();
        test_stream();
        test_flush();
        test_ex();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_instr_queue.md
ID_INSTR_QUEUE -- requirements
Module: id_instr_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two, >= 2.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 flush_i  input  1  synchronous flush from control unit (branch mispredict / exception).
REQ-005 valid_i  input  1  fetch presents an entry.
REQ-006 instr_i  input  32 (instruction_t)  fetched instruction word.
REQ-007 pc_i  input  64 (bus64_t)  PC of instr_i.
REQ-008 ex_valid_i  input  1  fetch-side exception (e.g. page fault) attached to entry.
REQ-009 ready_o  output  1  queue accepts an entry this cycle.
REQ-010 valid_o  output  1  head entry valid toward decode / immediate generation.
REQ-011 instr_o  output  32 (instruction_t)  head instruction.
REQ-012 pc_o  output  64  head PC.
REQ-013 ex_valid_o  output  1  head exception flag.
REQ-014 ready_i  input  1  decode consumes head this cycle.
REQ-015 count_o  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 Push SHALL occur iff valid_i && ready_o && !flush_i; entry {instr_i, pc_i, ex_valid_i} written at tail, tail pointer +1.
REQ-017 Pop SHALL occur iff valid_o && ready_i && !flush_i; head pointer +1.
REQ-018 ready_o SHALL equal (count < DEPTH), registered-state only, no combinational path from ready_i or valid_i.
REQ-019 valid_o SHALL equal (count != 0); no combinational path from valid_i (no bypass).
REQ-020 Latency: entry pushed at edge N SHALL appear at outputs in cycle after edge N at earliest (1 cycle).
REQ-021 Simultaneous push and pop SHALL leave count unchanged and both pointers advance; allowed whenever count in 1..DEPTH-1.
REQ-022 When full, push SHALL be blocked (ready_o=0) even if pop occurs that cycle.
REQ-023 Pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH; count tracked separately, range 0..DEPTH.
REQ-024 Entries SHALL leave in exact push order (FIFO); ex_valid travels with its instr/pc unchanged.
REQ-025 When valid_o=0, instr_o SHALL be 32'h00000013 (NOP), pc_o 0, ex_valid_o 0.
REQ-026 flush_i=1 SHALL, at next edge, set head=tail=0, count=0; same-cycle push and pop SHALL be discarded.
REQ-027 Storage array contents need not be cleared by flush or reset; only pointers/count.

Reset
REQ-028 On rstn_i low, asynchronously: head=0, tail=0, count=0; hence valid_o=0, ready_o=1, count_o=0, instr_o=NOP, pc_o=0, ex_valid_o=0.
REQ-029 Reset asserted mid-operation SHALL drop all pending entries; first push after release behaves as from empty.

Structure
REQ-030 Entry typedef fetch_entry_t {instruction_t instr; bus64_t pc; logic ex_valid} and constant INSTR_QUEUE_DEPTH SHALL live in drac_pkg.
REQ-031 Single module, no sub-modules; storage is an internal array of fetch_entry_t indexed by head/tail.

Verification
REQ-032 Reset then push pc=0x80000000 instr=0x00500093 ex=0, ready_i=1 -> next cycle valid_o=1, instr_o=0x00500093, pc_o=0x80000000; following cycle valid_o=0, instr_o=0x00000013.
REQ-033 ready_i=0, push 5 entries on consecutive cycles (DEPTH=4) -> ready_o=0 after 4th, count_o=4, 5th not stored; then ready_i=1 pops pc order 0x0,0x4,0x8,0xC.
REQ-034 Steady stream valid_i=1, ready_i=1 for 12 cycles -> count_o stays 1, pointers wrap three times, output pcs strictly sequential, no drops.
REQ-035 Count=3, flush_i=1 with valid_i=1 and ready_i=1 -> next cycle count_o=0, valid_o=0, ready_o=1; flushed entries never emitted.
REQ-036 Push entry with ex_valid_i=1 between two normal entries -> ex_valid_o=1 only on the middle entry's output cycle.
REQ-037 Count=2, drop rstn_i asynchronously mid-cycle -> valid_o=0 and count_o=0 immediately, without clock edge.
